// File: rtl/logic_exec_stage.sv
// Registered execute stage for the ALU bitwise path: one result register plus a
// one-entry skid so in_ready is a pure flop output and throughput stays at 1 op/cycle.
module logic_exec_stage #(
    parameter int WIDTH = 32,
    parameter int TAGW  = 5,
    parameter int CNTW  = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [TAGW-1:0]  tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             is_zero,
    output logic             illegal,
    output logic [TAGW-1:0]  tag_out,
    output logic [CNTW-1:0]  op_count,
    input  logic             clr_count
);

    function automatic logic [WIDTH-1:0] logic_op(input logic [2:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        case (op)
            3'd0:    logic_op = a & b;
            3'd1:    logic_op = a | b;
            3'd2:    logic_op = a ^ b;
            3'd3:    logic_op = ~(a | b);
            3'd4:    logic_op = a & ~b;
            3'd5:    logic_op = a;
            default: logic_op = '0;
        endcase
    endfunction

    logic             out_valid_q, out_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] out_res_q, out_res_d, skid_res_q, skid_res_d;
    logic             out_zero_q, out_zero_d, skid_zero_q, skid_zero_d;
    logic             out_ill_q, out_ill_d, skid_ill_q, skid_ill_d;
    logic [TAGW-1:0]  out_tag_q, out_tag_d, skid_tag_q, skid_tag_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;

    logic             push, pop;
    logic [WIDTH-1:0] new_res;
    logic             new_zero, new_ill;

    assign new_res  = logic_op(opcode, A, B);
    assign new_zero = (new_res == '0);
    assign new_ill  = (opcode > 3'd5);

    assign in_ready = !skid_valid_q;
    assign push     = in_valid && !skid_valid_q;
    assign pop      = out_valid_q && out_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        out_res_d    = out_res_q;
        out_zero_d   = out_zero_q;
        out_ill_d    = out_ill_q;
        out_tag_d    = out_tag_q;
        skid_res_d   = skid_res_q;
        skid_zero_d  = skid_zero_q;
        skid_ill_d   = skid_ill_q;
        skid_tag_d   = skid_tag_q;
        cnt_d        = cnt_q;

        if (skid_valid_q) begin
            // Skid holds the older op, so it must reach the output before anything new.
            if (pop) begin
                out_res_d    = skid_res_q;
                out_zero_d   = skid_zero_q;
                out_ill_d    = skid_ill_q;
                out_tag_d    = skid_tag_q;
                skid_valid_d = 1'b0;
            end
        end else if (push) begin
            if (!out_valid_q || pop) begin
                out_res_d   = new_res;
                out_zero_d  = new_zero;
                out_ill_d   = new_ill;
                out_tag_d   = tag_in;
                out_valid_d = 1'b1;
            end else begin
                skid_res_d   = new_res;
                skid_zero_d  = new_zero;
                skid_ill_d   = new_ill;
                skid_tag_d   = tag_in;
                skid_valid_d = 1'b1;
            end
        end else if (pop) begin
            out_valid_d = 1'b0;
        end

        if (clr_count) begin
            cnt_d = '0;
        end else if (pop && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_res_q    <= '0;
            out_zero_q   <= 1'b1;
            out_ill_q    <= 1'b0;
            out_tag_q    <= '0;
            skid_res_q   <= '0;
            skid_zero_q  <= 1'b1;
            skid_ill_q   <= 1'b0;
            skid_tag_q   <= '0;
            cnt_q        <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            out_res_q    <= out_res_d;
            out_zero_q   <= out_zero_d;
            out_ill_q    <= out_ill_d;
            out_tag_q    <= out_tag_d;
            skid_res_q   <= skid_res_d;
            skid_zero_q  <= skid_zero_d;
            skid_ill_q   <= skid_ill_d;
            skid_tag_q   <= skid_tag_d;
            cnt_q        <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign res       = out_res_q;
    assign is_zero   = out_zero_q;
    assign illegal   = out_ill_q;
    assign tag_out   = out_tag_q;
    assign op_count  = cnt_q;

endmodule

// File: tb/tb_logic_exec_stage.sv
// Bench for logic_exec_stage: directed scenarios plus random traffic, checked against a
// depth-2 FIFO reference model; a CNTW=4 copy shares the stimulus to exercise saturation.
module tb_logic_exec_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, out_ready, clr_count;
    logic [2:0]  opcode;
    logic [31:0] A, B;
    logic [4:0]  tag_in;

    logic        in_ready, out_valid, is_zero, illegal;
    logic [31:0] res;
    logic [4:0]  tag_out;
    logic [15:0] op_count;

    logic        s_in_ready, s_out_valid, s_is_zero, s_illegal;
    logic [31:0] s_res;
    logic [4:0]  s_tag_out;
    logic [3:0]  s_op_count;

    always #5 clock = ~clock;

    logic_exec_stage u_dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .A(A), .B(B), .tag_in(tag_in), .out_valid(out_valid),
        .out_ready(out_ready), .res(res), .is_zero(is_zero), .illegal(illegal),
        .tag_out(tag_out), .op_count(op_count), .clr_count(clr_count)
    );

    logic_exec_stage #(.CNTW(4)) u_sat (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
        .opcode(opcode), .A(A), .B(B), .tag_in(tag_in), .out_valid(s_out_valid),
        .out_ready(out_ready), .res(s_res), .is_zero(s_is_zero), .illegal(s_illegal),
        .tag_out(s_tag_out), .op_count(s_op_count), .clr_count(clr_count)
    );

    typedef struct {
        logic [31:0] r;
        logic        z;
        logic        ill;
        logic [4:0]  tg;
    } entry_t;

    entry_t q[$];
    int     cnt_m, cnt4_m;
    int     n_chk, n_pass;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic entry_t ref_op(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b, input logic [4:0] tg);
        entry_t e;
        case (op)
            0: e.r = a & b;
            1: e.r = a | b;
            2: e.r = a ^ b;
            3: e.r = ~(a | b);
            4: e.r = a & ~b;
            5: e.r = a;
            default: e.r = 32'h0;
        endcase
        e.ill = (op >= 6);
        e.z   = (e.r == 32'h0);
        e.tg  = tg;
        return e;
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Check outputs at the falling edge, then advance the model across the next rising edge.
    task automatic tick();
        bit push, pop;
        @(negedge clock);
        check("out_valid", out_valid, q.size() > 0);
        check("in_ready", in_ready, q.size() < 2);
        check("op_count", op_count, cnt_m);
        check("op_count4", s_op_count, cnt4_m);
        if (q.size() > 0) begin
            check("res", res, q[0].r);
            check("is_zero", is_zero, q[0].z);
            check("illegal", illegal, q[0].ill);
            check("tag_out", tag_out, q[0].tg);
        end
        push = in_valid && (q.size() < 2);
        pop  = out_ready && (q.size() > 0);
        if (pop) void'(q.pop_front());
        if (push) q.push_back(ref_op(opcode, A, B, tag_in));
        if (clr_count) begin
            cnt_m = 0;
            cnt4_m = 0;
        end else if (pop) begin
            if (cnt_m < 65535) cnt_m++;
            if (cnt4_m < 15) cnt4_m++;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic set_op(input logic v, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tg);
        in_valid = v;
        opcode   = op;
        A        = a;
        B        = b;
        tag_in   = tg;
    endtask

    initial begin
        n_chk = 0; n_pass = 0; cnt_m = 0; cnt4_m = 0;
        reset = 1'b1; out_ready = 1'b0; clr_count = 1'b0;
        set_op(1'b0, 3'd0, 32'h0, 32'h0, 5'd0);
        repeat (2) @(posedge clock);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_res", res, 32'h0);
        check("rst_is_zero", is_zero, 1'b1);
        check("rst_illegal", illegal, 1'b0);
        check("rst_tag_out", tag_out, 5'd0);
        check("rst_op_count", op_count, 16'd0);
        reset = 1'b0;
        tick();

        // Single AND op, unstalled
        out_ready = 1'b1;
        set_op(1'b1, 3'd0, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd3);
        tick();
        in_valid = 1'b0;
        check("and_res", res, 32'h00F0_1200);
        check("and_tag", tag_out, 5'd3);
        check("and_zero", is_zero, 1'b0);
        tick();
        check("and_count", op_count, 16'd1);

        // Back-to-back OR, XOR, NOR, ANDN, PASS_A
        for (int i = 1; i <= 5; i++) begin
            set_op(1'b1, 3'(i), 32'hAAAA_AAAA, 32'h5555_5555, 5'(i));
            tick();
            check("b2b_valid", out_valid, 1'b1);
            if (i == 3) check("nor_zero", is_zero, 1'b1);
        end
        in_valid = 1'b0;
        tick();
        check("b2b_count", op_count, 16'd6);

        // Backpressure: tags 1,2,3 with out_ready low
        out_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            set_op(1'b1, 3'd1, 32'h0000_0F00 | 32'(i), 32'h0, 5'(i));
            tick();
        end
        check("bp_in_ready", in_ready, 1'b0);
        check("bp_hold_tag", tag_out, 5'd1);
        tick();
        check("bp_hold_tag2", tag_out, 5'd1);
        out_ready = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        repeat (3) tick();

        // Illegal opcode
        set_op(1'b1, 3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9);
        tick();
        in_valid = 1'b0;
        check("ill_flag", illegal, 1'b1);
        check("ill_res", res, 32'h0);
        check("ill_zero", is_zero, 1'b1);
        tick();

        // Saturate the 4-bit counter, then clear together with a pop
        for (int i = 0; i < 20; i++) begin
            set_op(1'b1, 3'($urandom_range(0, 7)), rand_word(), rand_word(), 5'(i));
            tick();
        end
        check("sat_count4", s_op_count, 4'd15);
        clr_count = 1'b1;
        tick();
        clr_count = 1'b0;
        check("clr_count4", s_op_count, 4'd0);
        check("clr_count", op_count, 16'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            set_op($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), rand_word(),
                   rand_word(), 5'($urandom));
            out_ready = $urandom_range(0, 2) != 0;
            clr_count = $urandom_range(0, 199) == 0;
            tick();
        end
        clr_count = 1'b0;

        // Reset with both entries full and output stalled
        out_ready = 1'b0;
        set_op(1'b1, 3'd5, 32'h1234_5678, 32'h0, 5'd7);
        repeat (4) tick();
        check("full_in_ready", in_ready, 1'b0);
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("async_out_valid", out_valid, 1'b0);
        check("async_in_ready", in_ready, 1'b1);
        check("async_res", res, 32'h0);
        check("async_op_count", op_count, 16'd0);
        q.delete();
        cnt_m = 0;
        cnt4_m = 0;
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        check("post_rst_valid", out_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
